// File: rtl/fifo_bridge_pkg.sv
// Shared definitions for the MCU/CPU byte FIFO bridge.
package fifo_bridge_pkg;

    // Status byte bit positions
    localparam int unsigned FIFO_ST_EMPTY  = 7;
    localparam int unsigned FIFO_ST_FULL   = 6;
    localparam int unsigned FIFO_ST_OVF_TX = 5;
    localparam int unsigned FIFO_ST_OVF_RX = 4;

    localparam int unsigned DATA_W = 8;

    // Head prefetch sequencer states
    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_FETCH = 2'd1,
        PF_LOAD  = 2'd2
    } pf_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Single byte queue: RAM, wrap-bit pointers, registered head with prefetch, sticky overflow.
module byte_fifo
    import fifo_bridge_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 11,
    parameter logic [7:0]  EMPTY_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       ovf_clr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       head_vld,
    output logic       empty,
    output logic       full,
    output logic       ovf
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] ram_q;
    pf_state_t         state;
    logic              pop_ok;
    logic              push_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // A pop only counts once the head is loaded; a pop frees a slot for a same-cycle push.
    assign pop_ok  = pop && head_vld;
    assign push_ok = push && (!full || pop_ok);

    assign dout = head_vld ? head : EMPTY_BYTE;

    // RAM write port and prefetch read port (contents are not reset)
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
        end
        if (state == PF_FETCH) begin
            ram_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    // Pointers, overflow flag and head prefetch sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head     <= EMPTY_BYTE;
            head_vld <= 1'b0;
            ovf      <= 1'b0;
            state    <= PF_IDLE;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                head_vld <= 1'b0;
            end
            if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (push && !push_ok) begin
                ovf <= 1'b1;
            end
            case (state)
                PF_IDLE: begin
                    if (!empty && !head_vld) begin
                        state <= PF_FETCH;
                    end
                end
                PF_FETCH: begin
                    state <= PF_LOAD;
                end
                PF_LOAD: begin
                    head     <= ram_q;
                    head_vld <= 1'b1;
                    state    <= PF_IDLE;
                end
                default: begin
                    state <= PF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_bridge.sv
// Bidirectional byte bridge between the MCU (pi) side and the CPU register window.
module fifo_bridge
    import fifo_bridge_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 11,
    parameter logic [7:0]  EMPTY_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_wr,
    input  logic       cpu_rd_end,
    input  logic       cpu_st_rd_end,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic [7:0] cpu_stat,
    input  logic       pi_wr,
    input  logic       pi_rd,
    input  logic [7:0] pi_din,
    output logic [7:0] pi_dout,
    output logic [7:0] pi_stat,
    output logic       mcu_rxf
);

    logic m2c_vld;
    logic m2c_full;
    logic m2c_ovf;
    logic m2c_empty_unused;
    logic c2m_vld;
    logic c2m_full;
    logic c2m_ovf;
    logic c2m_empty;

    // MCU to CPU queue; its overflow flag has no clearing strobe on this side
    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .EMPTY_BYTE (EMPTY_BYTE)
    ) u_m2c (
        .clk      (clk),
        .rst      (rst),
        .push     (pi_wr),
        .pop      (cpu_rd_end),
        .ovf_clr  (1'b0),
        .din      (pi_din),
        .dout     (cpu_dout),
        .head_vld (m2c_vld),
        .empty    (m2c_empty_unused),
        .full     (m2c_full),
        .ovf      (m2c_ovf)
    );

    // CPU to MCU queue; a CPU status read clears its overflow flag
    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .EMPTY_BYTE (EMPTY_BYTE)
    ) u_c2m (
        .clk      (clk),
        .rst      (rst),
        .push     (cpu_wr),
        .pop      (pi_rd),
        .ovf_clr  (cpu_st_rd_end),
        .din      (cpu_din),
        .dout     (pi_dout),
        .head_vld (c2m_vld),
        .empty    (c2m_empty),
        .full     (c2m_full),
        .ovf      (c2m_ovf)
    );

    // Status bytes, each seen from its own side
    always_comb begin
        cpu_stat                 = '0;
        cpu_stat[FIFO_ST_EMPTY]  = !m2c_vld;
        cpu_stat[FIFO_ST_FULL]   = c2m_full;
        cpu_stat[FIFO_ST_OVF_TX] = c2m_ovf;
        cpu_stat[FIFO_ST_OVF_RX] = m2c_ovf;

        pi_stat                  = '0;
        pi_stat[FIFO_ST_EMPTY]   = !c2m_vld;
        pi_stat[FIFO_ST_FULL]    = m2c_full;
        pi_stat[FIFO_ST_OVF_TX]  = m2c_ovf;
        pi_stat[FIFO_ST_OVF_RX]  = c2m_ovf;
    end

    // Tell the MCU the CPU has queued data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcu_rxf <= 1'b0;
        end else begin
            mcu_rxf <= !c2m_empty;
        end
    end

endmodule

// File: tb/tb_fifo_bridge.sv
// Self-checking bench for fifo_bridge: vector table, scoreboard queues, corner sequences.
module tb_fifo_bridge;

    localparam int unsigned DEPTH = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_wr = 1'b0;
    logic       cpu_rd_end = 1'b0;
    logic       cpu_st_rd_end = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic [7:0] cpu_dout;
    logic [7:0] cpu_stat;
    logic       pi_wr = 1'b0;
    logic       pi_rd = 1'b0;
    logic [7:0] pi_din = 8'h00;
    logic [7:0] pi_dout;
    logic [7:0] pi_stat;
    logic       mcu_rxf;

    fifo_bridge #(
        .DEPTH_LOG2 (11),
        .EMPTY_BYTE (8'hFF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_wr        (cpu_wr),
        .cpu_rd_end    (cpu_rd_end),
        .cpu_st_rd_end (cpu_st_rd_end),
        .cpu_din       (cpu_din),
        .cpu_dout      (cpu_dout),
        .cpu_stat      (cpu_stat),
        .pi_wr         (pi_wr),
        .pi_rd         (pi_rd),
        .pi_din        (pi_din),
        .pi_dout       (pi_dout),
        .pi_stat       (pi_stat),
        .mcu_rxf       (mcu_rxf)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m2c_q[$];
    logic [7:0] c2m_q[$];
    bit         m2c_ovf = 1'b0;
    bit         c2m_ovf = 1'b0;

    typedef enum int {OP_NONE, OP_PIWR, OP_CPURD, OP_CPUWR, OP_PIRD, OP_STRD} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] data;
        logic [7:0] cpu_dout;
        logic [7:0] cpu_stat;
        logic [7:0] pi_dout;
        logic [7:0] pi_stat;
        logic       rxf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of strobes, compare heads being popped, update the model, then idle.
    task automatic step(input bit piwr, input logic [7:0] pd, input bit cpurd,
                        input bit cpuwr, input logic [7:0] cd, input bit pird,
                        input bit strd, input int gap);
        if (cpurd && m2c_q.size() > 0) chk("m2c_head", cpu_dout, m2c_q[0]);
        if (pird && c2m_q.size() > 0) chk("c2m_head", pi_dout, c2m_q[0]);
        pi_wr = piwr; pi_din = pd; cpu_rd_end = cpurd;
        cpu_wr = cpuwr; cpu_din = cd; pi_rd = pird; cpu_st_rd_end = strd;
        tick();
        pi_wr = 1'b0; cpu_rd_end = 1'b0; cpu_wr = 1'b0; pi_rd = 1'b0; cpu_st_rd_end = 1'b0;
        if (cpurd && m2c_q.size() > 0) void'(m2c_q.pop_front());
        if (piwr) begin
            if (m2c_q.size() < DEPTH) m2c_q.push_back(pd);
            else m2c_ovf = 1'b1;
        end
        if (pird && c2m_q.size() > 0) void'(c2m_q.pop_front());
        if (strd) c2m_ovf = 1'b0;
        if (cpuwr) begin
            if (c2m_q.size() < DEPTH) c2m_q.push_back(cd);
            else c2m_ovf = 1'b1;
        end
        repeat (gap - 1) tick();
    endtask

    // Compare every output against the scoreboard-derived expectation.
    task automatic check_all(input string tag);
        logic [7:0] e_cd, e_pd, e_cs, e_ps;
        e_cd = (m2c_q.size() == 0) ? 8'hFF : m2c_q[0];
        e_pd = (c2m_q.size() == 0) ? 8'hFF : c2m_q[0];
        e_cs = {(m2c_q.size() == 0), (c2m_q.size() == DEPTH), c2m_ovf, m2c_ovf, 4'h0};
        e_ps = {(c2m_q.size() == 0), (m2c_q.size() == DEPTH), m2c_ovf, c2m_ovf, 4'h0};
        chk($sformatf("%s.cpu_dout", tag), cpu_dout, e_cd);
        chk($sformatf("%s.pi_dout", tag), pi_dout, e_pd);
        chk($sformatf("%s.cpu_stat", tag), cpu_stat, e_cs);
        chk($sformatf("%s.pi_stat", tag), pi_stat, e_ps);
        chk($sformatf("%s.mcu_rxf", tag), 8'(mcu_rxf), 8'(c2m_q.size() != 0));
    endtask

    initial begin
        int pushes;
        int r;
        bit pw;
        bit pr;

        //            op        data   cpu_dout cpu_stat pi_dout pi_stat rxf
        vecs[0] = '{OP_NONE,  8'h00, 8'hFF, 8'h80, 8'hFF, 8'h80, 1'b0};
        vecs[1] = '{OP_PIWR,  8'h5A, 8'h5A, 8'h00, 8'hFF, 8'h80, 1'b0};
        vecs[2] = '{OP_CPURD, 8'h00, 8'hFF, 8'h80, 8'hFF, 8'h80, 1'b0};
        vecs[3] = '{OP_CPUWR, 8'h33, 8'hFF, 8'h80, 8'h33, 8'h00, 1'b1};
        vecs[4] = '{OP_CPUWR, 8'h44, 8'hFF, 8'h80, 8'h33, 8'h00, 1'b1};
        vecs[5] = '{OP_PIRD,  8'h00, 8'hFF, 8'h80, 8'h44, 8'h00, 1'b1};
        vecs[6] = '{OP_PIRD,  8'h00, 8'hFF, 8'h80, 8'hFF, 8'h80, 1'b0};
        vecs[7] = '{OP_CPURD, 8'h00, 8'hFF, 8'h80, 8'hFF, 8'h80, 1'b0};
        vecs[8] = '{OP_PIRD,  8'h00, 8'hFF, 8'h80, 8'hFF, 8'h80, 1'b0};

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic transfers and ignored pops on empty
        for (int i = 0; i < 9; i++) begin
            case (vecs[i].op)
                OP_PIWR:  step(1'b1, vecs[i].data, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4);
                OP_CPURD: step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4);
                OP_CPUWR: step(1'b0, 8'h00, 1'b0, 1'b1, vecs[i].data, 1'b0, 1'b0, 4);
                OP_PIRD:  step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4);
                OP_STRD:  step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4);
                default:  tick();
            endcase
            chk($sformatf("vec%0d.cpu_dout", i), cpu_dout, vecs[i].cpu_dout);
            chk($sformatf("vec%0d.cpu_stat", i), cpu_stat, vecs[i].cpu_stat);
            chk($sformatf("vec%0d.pi_dout", i), pi_dout, vecs[i].pi_dout);
            chk($sformatf("vec%0d.pi_stat", i), pi_stat, vecs[i].pi_stat);
            chk($sformatf("vec%0d.mcu_rxf", i), 8'(mcu_rxf), 8'(vecs[i].rxf));
        end

        // 16 bytes CPU to MCU, drained in order
        for (int i = 1; i <= 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 4);
        chk("rxf_after_16", 8'(mcu_rxf), 8'h01);
        chk("c2m_first_head", pi_dout, 8'h01);
        for (int i = 1; i <= 16; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4);
        chk("rxf_after_drain", 8'(mcu_rxf), 8'h00);
        chk("pi_dout_after_drain", pi_dout, 8'hFF);
        check_all("c2m16");

        // Fill both queues to full, then overflow each
        for (int i = 0; i < int'(DEPTH); i++)
            step(1'b1, 8'(i % 128), 1'b0, 1'b1, 8'(i % 100), 1'b0, 1'b0, 4);
        chk("m2c_full", 8'(pi_stat[6]), 8'h01);
        chk("c2m_full", 8'(cpu_stat[6]), 8'h01);
        check_all("full");
        step(1'b1, 8'hEE, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 4);
        chk("m2c_ovf_cpu", 8'(cpu_stat[4]), 8'h01);
        chk("c2m_ovf_cpu", 8'(cpu_stat[5]), 8'h01);
        check_all("ovf");
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4);
        chk("c2m_ovf_clr", 8'(cpu_stat[5]), 8'h00);
        chk("m2c_ovf_sticky", 8'(pi_stat[5]), 8'h01);
        check_all("ovf_clr");

        // Drain both; the dropped 8'hEE must never surface
        for (int i = 0; i < int'(DEPTH); i++)
            step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4);
        check_all("drained");

        // Refill M2C, then push with a simultaneous pop while full
        for (int i = 0; i < int'(DEPTH); i++)
            step(1'b1, 8'(i * 7), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4);
        step(1'b1, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4);
        chk("full_push_pop_full", 8'(pi_stat[6]), 8'h01);
        chk("full_push_pop_ovf", 8'(cpu_stat[4]), 8'h01);
        check_all("full_push_pop");

        // Random push/pop traffic across pointer wrap
        pushes = 0;
        while (pushes < 5000) begin
            r  = int'($urandom_range(0, 2));
            pw = (r != 1);
            pr = (r != 0);
            step(pw, 8'($urandom_range(0, 255)), pr, 1'b0, 8'h00, 1'b0, 1'b0,
                 int'($urandom_range(4, 6)));
            if (pw) pushes++;
            chk("wrap_full", 8'(pi_stat[6]), 8'(m2c_q.size() == DEPTH));
            chk("wrap_empty", 8'(cpu_stat[7]), 8'(m2c_q.size() == 0));
        end
        check_all("wrap");

        // Reset asserted while the M2C head prefetch is in FETCH
        step(1'b1, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 4);
        step(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2);
        rst = 1'b1;
        #1;
        chk("rst_cpu_dout", cpu_dout, 8'hFF);
        chk("rst_cpu_stat", cpu_stat, 8'h80);
        chk("rst_pi_dout", pi_dout, 8'hFF);
        chk("rst_pi_stat", pi_stat, 8'h80);
        chk("rst_mcu_rxf", 8'(mcu_rxf), 8'h00);
        m2c_q.delete();
        c2m_q.delete();
        m2c_ovf = 1'b0;
        c2m_ovf = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_all("post_rst");
        step(1'b1, 8'hA5, 1'b0, 1'b1, 8'h5C, 1'b0, 1'b0, 4);
        check_all("post_rst_push");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4);
        check_all("post_rst_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
